// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin select arbiters.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int unsigned MaxPorts = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // One-hot vector with bit idx set; callers truncate to their port count.
  function automatic logic [MaxPorts-1:0] onehot_from_idx(input logic [3:0] idx);
    return {{(MaxPorts-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set bit of reqMask at or after startPtr, modulo PortCount.
module rr_priority_pick #(
  parameter int unsigned PortCount = 4,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic [PortCount-1:0] reqMask,
  input  logic [IdxWidth-1:0]  startPtr,
  output logic                 found,
  output logic [IdxWidth-1:0]  idx
);

  logic [2*PortCount-1:0] doubled;
  logic [PortCount-1:0]   rotated;
  logic                   hit;
  int unsigned            offset;
  int unsigned            sum;

  // Rotate so startPtr becomes bit 0, fixed-priority encode, then un-rotate with explicit modulo.
  always_comb begin
    doubled = {reqMask, reqMask};
    rotated = doubled[startPtr +: PortCount];
    found   = |rotated;
    hit     = 1'b0;
    offset  = 0;
    for (int unsigned k = 0; k < PortCount; k++) begin
      if (rotated[k] && !hit) begin
        offset = k;
        hit    = 1'b1;
      end
    end
    sum = offset + 32'(startPtr);
    if (sum >= PortCount) sum = sum - PortCount;
    idx = IdxWidth'(sum);
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter with burst lock; drives the sel of a downstream Multiplexer.
module rr_select_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned PortCount = 4,
  parameter int unsigned BitWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PortCount-1:0] req,
  input  logic [PortCount-1:0] last,
  input  logic                 out_ready,
  output logic [PortCount-1:0] sel,
  output logic [PortCount-1:0] grant,
  output logic                 out_valid,
  output logic [PortCount-1:0] src_ready
);

  localparam int unsigned IdxWidth = clog2_min1(PortCount);

  if (PortCount < 2 || PortCount > MaxPorts || BitWidth < 1) begin : gParamCheck
    $error("rr_select_arbiter: PortCount must be 2..16 and BitWidth at least 1");
  end

  arb_state_t           state, stateNext;
  logic [IdxWidth-1:0]  ptr, ptrNext;
  logic [IdxWidth-1:0]  selIdx, selNext;
  logic [PortCount-1:0] grantNext;
  logic [IdxWidth-1:0]  nextPtr, pickStart, pickIdx;
  logic [PortCount-1:0] pickMask;
  logic                 pickFound;
  logic                 burstEnd;

  assign nextPtr   = (selIdx == IdxWidth'(PortCount - 1)) ? '0 : selIdx + 1'b1;
  assign burstEnd  = (state == BUSY) && req[selIdx] && last[selIdx] && out_ready;
  // At burst end the finishing owner is masked out; it can win again only via IDLE.
  assign pickMask  = (state == BUSY) ? (req & ~grant) : req;
  assign pickStart = (state == BUSY) ? nextPtr : ptr;

  rr_priority_pick #(
    .PortCount (PortCount),
    .IdxWidth  (IdxWidth)
  ) uPick (
    .reqMask  (pickMask),
    .startPtr (pickStart),
    .found    (pickFound),
    .idx      (pickIdx)
  );

  // State, pointer and owner registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      selIdx <= '0;
      grant  <= '0;
    end else begin
      state  <= stateNext;
      ptr    <= ptrNext;
      selIdx <= selNext;
      grant  <= grantNext;
    end
  end

  // Next owner: grant from IDLE, hold while locked, re-arbitrate on the accepting last beat.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    selNext   = selIdx;
    grantNext = grant;
    unique case (state)
      IDLE: begin
        if (pickFound) begin
          selNext   = pickIdx;
          grantNext = PortCount'(onehot_from_idx(4'(pickIdx)));
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (burstEnd) begin
          ptrNext = nextPtr;
          if (pickFound) begin
            selNext   = pickIdx;
            grantNext = PortCount'(onehot_from_idx(4'(pickIdx)));
          end else begin
            grantNext = '0;
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  assign sel       = PortCount'(selIdx);
  assign out_valid = (state == BUSY) && req[selIdx];
  assign src_ready = grant & {PortCount{out_ready}};

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Round-robin arbiter with burst lock; generates the `sel` index that drives the library `Multiplexer` directly downstream.
- Chooses one of PortCount requesters and holds that grant until the requester's final beat is accepted by the consumer.
- Exports a one-hot grant so each source sees its ready.
- Sits between N packet sources and one shared sink; the mux carries data and this block carries control.

Parameters:
- PortCount, 4, number of requesters; legal range 2..16.
- BitWidth, 8, unused internally; carried so instantiation matches the paired `Multiplexer`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  PortCount  per-source valid; req[i]=1 means source i has a beat.
- last  input  PortCount  per-source end-of-burst flag; meaningful only with req[i].
- out_ready  input  1  downstream sink accepts a beat this cycle.
- sel  output  PortCount  binary index of the owner; connects to `Multiplexer.sel`; upper bits zero.
- grant  output  PortCount  one-hot owner; all-zero when idle.
- out_valid  output  1  asserted when the owner presents a beat: `req[sel] && state==BUSY`.
- src_ready  output  PortCount  `grant & {PortCount{out_ready}}`; the ready returned to sources.

Behaviour:
- Reset, asynchronous, active on `rst_n`=0:
  - state=IDLE, ptr=0, sel=0, grant=0.
  - out_valid=0 and src_ready=0 immediately.
- State IDLE:
  - If `|req`, pick the first i with req[i]=1, scanning ptr, ptr+1, ... modulo PortCount.
  - Register sel=i and grant=1<<i; next state BUSY.
  - Latency is one cycle: req seen on edge N gives out_valid high after edge N.
- State BUSY:
  - A beat transfers when `req[sel] && out_ready`.
  - A transfer with `last[sel]`=1 ends the burst.
  - Burst end: ptr <= sel+1, wrapping PortCount-1 -> 0.
  - Burst end with any other requester active: re-arbitrate on the same edge using the new ptr, stay BUSY, no bubble cycle.
  - Burst end with no other requester: go to IDLE with grant=0; sel holds its old value.
  - At burst end, the finishing requester is eligible again only if no other request is pending. It is last in priority because ptr has moved past it.
- Lock: while BUSY, the grant never changes unless a last beat transfers.
  - If the owner deasserts req mid-burst, out_valid drops and the grant is held.
  - Other requesters wait.
- Simultaneous requests in IDLE: the rotating priority decides; ptr changes only at burst end, never at grant time.
- Single-beat burst: req and last high together, with out_ready high. The transfer completes in one BUSY cycle.
- last without req is ignored. A last beat with out_ready=0 does not release; release happens only on the accepting edge.
- Reset asserted mid-burst aborts immediately. No recovery of the partial burst; sources must restart.
- ptr width is ceil(log2(PortCount)). Wrap arithmetic is explicit modulo, not a power-of-two overflow.
- Combinational paths:
  - req -> out_valid.
  - out_ready -> src_ready.
  - There is no path from out_ready to sel or grant within a cycle.

Decomposition:
- Package `arb_pkg`:
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - Function clog2_min1(n), for ptr width.
  - Function onehot_from_idx.
- Sub-module `rr_priority_pick` (combinational):
  - Inputs: req mask, start ptr.
  - Outputs: found flag, index.
  - Implemented as a rotate, fixed-priority encode, un-rotate.
  - Reused by any future arbiters.

Test Plan (PortCount=4):
- Reset then idle: rst_n low with req=4'b1111 -> grant=0, out_valid=0, sel=0. After release, the first edge grants sel=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111, each burst is one beat (last=1), out_ready=1.
  - Required: sel sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
- Burst lock:
  - Stimulus: port 2 granted with a 3-beat burst; req[0] is raised mid-burst; out_ready toggles 1,0,1,1.
  - Required: sel stays 2 until the third accepted beat; then sel=0 on the next edge.
- Owner stall: owner deasserts req for 2 cycles mid-burst -> out_valid=0 for those cycles; grant unchanged; other requesters not served.
- Wrap and skip:
  - Stimulus: ptr=3 after port 2 finishes; req=4'b0101.
  - Required: sel=0 (wrap, since 3 is idle), then sel=2 after port 0's last.
- Mid-burst reset: rst_n pulsed low while BUSY -> grant=0 and src_ready=0 asynchronously; after release, arbitration restarts from ptr=0.
